top_whirlpool_hash: RTL and testbench

TOP_WHIRLPOOL_HASH -- requirements
Module: top_whirlpool_hash

---
 rtl/whirlpool_pkg.sv | 70 +++++++
 rtl/whirlpool_round.sv | 42 ++++
 rtl/top_whirlpool_hash.sv | 137 +++++++++++++
 tb/tb_top_whirlpool_hash.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/whirlpool_pkg.sv
// Shared Whirlpool constants and helpers: S-box, round constants, MixRows
// coefficients, GF(2^8) multiply, and the hashing FSM state type.
package whirlpool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUND1,
    ST_FIN1,
    ST_ROUND2,
    ST_FIN2
  } state_e;

  // Mini-boxes of the S-box construction; entry 0 is the top nibble.
  localparam logic [63:0] MINI_E    = 64'h1B9CD6F3E874A250;
  localparam logic [63:0] MINI_EINV = 64'hF0D7BE5A92C13486;
  localparam logic [63:0] MINI_R    = 64'h7CBDE49F638A2510;

  // First row of the MixRows circulant, coefficient 0 in the top byte.
  localparam logic [63:0] MIX_COEF = 64'h0101040108050209;

  function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] idx);
    return tbl[63 - 4 * int'(idx) -: 4];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [3:0] a, b, r;
    a = nib(MINI_E, x[7:4]);
    b = nib(MINI_EINV, x[3:0]);
    r = nib(MINI_R, a ^ b);
    return {nib(MINI_E, a ^ r), nib(MINI_EINV, b ^ r)};
  endfunction

  function automatic logic [2047:0] gen_sbox();
    logic [2047:0] tbl;
    tbl = '0;
    for (int i = 0; i < 256; i++) begin
      tbl[2047 - 8 * i -: 8] = sbox_calc(8'(i));
    end
    return tbl;
  endfunction

  // 256x8 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = gen_sbox();

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  // Row 0 of c_r is eight consecutive S-box entries; idx = r-1.
  function automatic logic [63:0] round_const(input logic [4:0] idx);
    return SBOX[2047 - 64 * int'(idx) -: 64];
  endfunction

  function automatic logic [7:0] mix_coef(input int idx);
    return MIX_COEF[63 - 8 * idx -: 8];
  endfunction

  // Multiply in GF(2^8) reduced by x^8+x^4+x^3+x^2+1 (0x11D).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/whirlpool_round.sv
// One combinational Whirlpool round rho[k]: SubBytes, ShiftColumns,
// MixRows, AddRoundKey. Byte n of the 8x8 state (row n/8, col n%8)
// sits at [511-8n -: 8].
module whirlpool_round
  import whirlpool_pkg::*;
(
  input  logic [511:0] state_i,
  input  logic [511:0] key_i,
  output logic [511:0] state_o
);

  logic [7:0] sub_b [64];
  logic [7:0] shf_b [64];

  genvar gi;

  for (gi = 0; gi < 64; gi++) begin : g_sub
    assign sub_b[gi] = sbox(state_i[511 - 8 * gi -: 8]);
  end

  // Column j is rotated down by j rows.
  for (gi = 0; gi < 64; gi++) begin : g_shift
    localparam int ROW = gi / 8;
    localparam int COL = gi % 8;
    assign shf_b[gi] = sub_b[((ROW - COL + 8) % 8) * 8 + COL];
  end

  for (gi = 0; gi < 64; gi++) begin : g_mix
    localparam int ROW = gi / 8;
    localparam int COL = gi % 8;
    logic [7:0] acc;
    // Row vector times the circulant: entry (k,j) is coefficient (j-k) mod 8.
    always_comb begin
      acc = '0;
      for (int k = 0; k < 8; k++) begin
        acc = acc ^ gf_mul(shf_b[ROW * 8 + k], mix_coef((COL - k + 8) % 8));
      end
    end
    assign state_o[511 - 8 * gi -: 8] = acc ^ key_i[511 - 8 * gi -: 8];
  end

endmodule

// File: rtl/top_whirlpool_hash.sv
// Whirlpool digest of pass(24 B) || salt(64 B): two compressions, one
// key round plus one state round per enabled cycle, 22-cycle latency.
module top_whirlpool_hash
  import whirlpool_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_pass_valid,
  input  logic         i_ena_hash,
  input  logic [511:0] i_salt,
  input  logic [191:0] i_pass,
  output logic [191:0] o_pass,
  output logic         o_key_valid,
  output logic [511:0] o_key
);

  localparam int CW = $clog2(ROUNDS + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  rnd_q, rnd_d;
  logic [511:0]   key_q, key_d;
  logic [511:0]   blk_q, blk_d;
  logic [511:0]   h_q, h_d;
  logic [191:0]   pass_q, pass_d;
  logic [511:0]   salt_q, salt_d;
  logic [511:0]   key_out_q, key_out_d;
  logic           valid_q, valid_d;

  logic [4:0]     rc_idx;
  logic [511:0]   rc_key, key_rnd, blk_rnd;
  logic [511:0]   block1, block2, h_fin;

  // Message blocks rebuilt from the captured inputs; padding is fixed for 88 bytes.
  assign block1 = {pass_q, salt_q[511:192]};
  assign block2 = {salt_q[191:0], 8'h80, 56'h0, 256'h2C0};
  assign h_fin  = blk_q ^ h_q ^ ((state_q == ST_FIN1) ? block1 : block2);

  assign rc_idx = 5'(rnd_q) - 5'd1;
  assign rc_key = {round_const(rc_idx), 448'h0};

  // Key path: K^r = rho[c_r](K^(r-1)).
  whirlpool_round u_key_round (
    .state_i (key_q),
    .key_i   (rc_key),
    .state_o (key_rnd)
  );

  // State path uses the freshly computed round key in the same cycle.
  whirlpool_round u_state_round (
    .state_i (blk_q),
    .key_i   (key_rnd),
    .state_o (blk_rnd)
  );

  // Next-state logic for the job sequence IDLE -> ROUND1 -> FIN1 -> ROUND2 -> FIN2.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    key_d     = key_q;
    blk_d     = blk_q;
    h_d       = h_q;
    pass_d    = pass_q;
    salt_d    = salt_q;
    key_out_d = key_out_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_pass_valid) begin
          pass_d  = i_pass;
          salt_d  = i_salt;
          key_d   = '0;
          h_d     = '0;
          blk_d   = {i_pass, i_salt[511:192]};
          rnd_d   = CW'(1);
          state_d = ST_ROUND1;
        end
      end
      ST_ROUND1, ST_ROUND2: begin
        key_d = key_rnd;
        blk_d = blk_rnd;
        if (rnd_q == CW'(ROUNDS)) begin
          rnd_d   = '0;
          state_d = (state_q == ST_ROUND1) ? ST_FIN1 : ST_FIN2;
        end else begin
          rnd_d = rnd_q + CW'(1);
        end
      end
      ST_FIN1: begin
        h_d     = h_fin;
        key_d   = h_fin;
        blk_d   = block2 ^ h_fin;
        rnd_d   = CW'(1);
        state_d = ST_ROUND2;
      end
      ST_FIN2: begin
        key_out_d = h_fin;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything but the one-cycle pulse freezes while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rnd_q     <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      h_q       <= '0;
      pass_q    <= '0;
      salt_q    <= '0;
      key_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= i_ena_hash & valid_d;
      if (i_ena_hash) begin
        state_q   <= state_d;
        rnd_q     <= rnd_d;
        key_q     <= key_d;
        blk_q     <= blk_d;
        h_q       <= h_d;
        pass_q    <= pass_d;
        salt_q    <= salt_d;
        key_out_q <= key_out_d;
      end
    end
  end

  assign o_pass      = pass_q;
  assign o_key       = key_out_q;
  assign o_key_valid = valid_q;

endmodule

// File: tb/tb_top_whirlpool_hash.sv
// Scoreboard bench for top_whirlpool_hash with an independent Whirlpool model.
module tb_top_whirlpool_hash;

  logic         clk = 1'b0;
  logic         rst;
  logic         pass_valid;
  logic         ena_hash;
  logic [511:0] salt;
  logic [191:0] pass;
  logic [191:0] o_pass;
  logic         o_key_valid;
  logic [511:0] o_key;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [511:0] key;
    logic [191:0] pass;
    int           acc_cyc;
    int           stall;
  } exp_t;

  exp_t sb_q[$];
  int   pulse_cycs[$];

  logic [7:0] tb_sb [256];

  localparam logic [511:0] WP_EMPTY =
    512'h19fa61d75522a4669b44e39c1d2e1726c530232130d407f89afee0964997f7a73e83be698b288febcf88e3e03c4f0757ea8964e59b63d93708b138cc42a66eb3;

  top_whirlpool_hash #(.ROUNDS(10)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pass_valid (pass_valid),
    .i_ena_hash   (ena_hash),
    .i_salt       (salt),
    .i_pass       (pass),
    .o_pass       (o_pass),
    .o_key_valid  (o_key_valid),
    .o_key        (o_key)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      if (x[7]) x = (x << 1) ^ 8'h1D;
      else      x = x << 1;
    end
    return p;
  endfunction

  function automatic logic [511:0] tb_rho(input logic [511:0] a, input logic [511:0] k);
    logic [7:0] s [8][8];
    logic [7:0] t [8][8];
    logic [7:0] cf [8];
    logic [7:0] acc;
    logic [511:0] r;
    cf = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        s[i][j] = tb_sb[a[511 - 8 * (8 * i + j) -: 8]];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        t[i][j] = s[(i - j + 8) % 8][j];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 8'h00;
        for (int q = 0; q < 8; q++) acc = acc ^ tb_gmul(t[i][q], cf[(j - q + 8) % 8]);
        r[511 - 8 * (8 * i + j) -: 8] = acc ^ k[511 - 8 * (8 * i + j) -: 8];
      end
    return r;
  endfunction

  function automatic logic [511:0] tb_compress(input logic [511:0] h, input logic [511:0] m);
    logic [511:0] kk, w;
    logic [63:0] rc;
    kk = h;
    w  = m ^ h;
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 8; j++) rc[63 - 8 * j -: 8] = tb_sb[8 * (r - 1) + j];
      kk = tb_rho(kk, {rc, 448'h0});
      w  = tb_rho(w, kk);
    end
    return w ^ h ^ m;
  endfunction

  function automatic logic [511:0] tb_hash88(input logic [191:0] p, input logic [511:0] s);
    logic [7:0] mb [128];
    logic [1023:0] flat;
    int lenbits;
    lenbits = 88 * 8;
    for (int i = 0; i < 128; i++) mb[i] = 8'h00;
    for (int i = 0; i < 24; i++) mb[i] = p[191 - 8 * i -: 8];
    for (int i = 0; i < 64; i++) mb[24 + i] = s[511 - 8 * i -: 8];
    mb[88] = 8'h80;
    for (int i = 0; i < 4; i++) mb[127 - i] = 8'((lenbits >> (8 * i)) & 255);
    for (int i = 0; i < 128; i++) flat[1023 - 8 * i -: 8] = mb[i];
    return tb_compress(tb_compress(512'h0, flat[1023:512]), flat[511:0]);
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst && o_key_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_pulse", 512'd1, 512'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("[TB] job done cyc=%0d latency=%0d key=%h", cyc, cyc - e.acc_cyc, o_key);
        check_eq("digest", o_key, e.key);
        check_eq("pass_out", {320'h0, o_pass}, {320'h0, e.pass});
        check_eq("latency", 512'(cyc - e.acc_cyc), 512'(22 + e.stall));
        pulse_cycs.push_back(cyc);
      end
    end
  end

  // Present a request for one cycle; accept happens on the next edge.
  task automatic submit(input logic [191:0] p, input logic [511:0] s, input int stall);
    exp_t e;
    pass       = p;
    salt       = s;
    pass_valid = 1'b1;
    e.key      = tb_hash88(p, s);
    e.pass     = p;
    e.acc_cyc  = cyc + 1;
    e.stall    = stall;
    sb_q.push_back(e);
    $display("[TB] submit cyc=%0d pass=%h", cyc + 1, p);
    @(negedge clk);
    pass_valid = 1'b0;
    check_eq("o_pass_capture", {320'h0, o_pass}, {320'h0, p});
  endtask

  task automatic wait_drain();
    int budget;
    budget = 200;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", 512'(sb_q.size()), 512'd0);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int me [16];
    int mi [16];
    int mr [16];
    int a, b, r;
    me = '{1, 11, 9, 12, 13, 6, 15, 3, 14, 8, 7, 4, 10, 2, 5, 0};
    mi = '{15, 0, 13, 7, 11, 14, 5, 10, 9, 2, 12, 1, 3, 4, 8, 6};
    mr = '{7, 12, 11, 13, 14, 4, 9, 15, 6, 3, 8, 10, 2, 5, 1, 0};
    for (int x = 0; x < 256; x++) begin
      a = me[x >> 4];
      b = mi[x & 15];
      r = mr[a ^ b];
      tb_sb[x] = 8'((me[a ^ r] << 4) | mi[b ^ r]);
    end

    // Model sanity against the published empty-string digest.
    check_eq("model_empty", tb_compress(512'h0, {8'h80, 504'h0}), WP_EMPTY);

    rst = 1'b1; pass_valid = 1'b0; ena_hash = 1'b1; pass = '0; salt = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_o_pass", {320'h0, o_pass}, 512'h0);
    check_eq("rst_o_key", o_key, 512'h0);
    check_eq("rst_o_valid", 512'(o_key_valid), 512'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle_o_pass", {320'h0, o_pass}, 512'h0);
    check_eq("idle_o_key", o_key, 512'h0);
    check_eq("idle_o_valid", 512'(o_key_valid), 512'h0);

    // Repeated pattern.
    submit({3{64'h0123456789abcdef}}, {8{64'h0123456789abcdef}}, 0);
    wait_drain();

    // All zeros.
    submit(192'h0, 512'h0, 0);
    wait_drain();

    // Enable dropped for 5 cycles during ROUND2.
    submit(rnd512()[191:0], rnd512(), 5);
    repeat (13) @(negedge clk);
    ena_hash = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_no_valid", 512'(o_key_valid), 512'h0);
    end
    ena_hash = 1'b1;
    wait_drain();

    // Reset in round 6 of block 1, then a fresh job.
    submit(rnd512()[191:0], rnd512(), 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check_eq("abort_o_pass", {320'h0, o_pass}, 512'h0);
    check_eq("abort_o_key", o_key, 512'h0);
    check_eq("abort_o_valid", 512'(o_key_valid), 512'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      check_eq("abort_no_pulse", 512'(o_key_valid), 512'h0);
    end
    submit(rnd512()[191:0], rnd512(), 0);
    wait_drain();

    // Back-to-back with valid held high and inputs changing every cycle.
    pulse_cycs.delete();
    for (int n = 0; n <= 46; n++) begin
      pass       = rnd512()[191:0];
      salt       = rnd512();
      pass_valid = 1'b1;
      if (n % 23 == 0) begin
        exp_t e;
        e.key     = tb_hash88(pass, salt);
        e.pass    = pass;
        e.acc_cyc = cyc + 1;
        e.stall   = 0;
        sb_q.push_back(e);
        $display("[TB] submit cyc=%0d pass=%h", cyc + 1, pass);
      end
      @(negedge clk);
    end
    pass_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      pass = rnd512()[191:0];
      salt = rnd512();
      @(negedge clk);
    end
    wait_drain();
    check_eq("b2b_pulse_count", 512'(pulse_cycs.size()), 512'd3);
    if (pulse_cycs.size() == 3) begin
      check_eq("b2b_gap0", 512'(pulse_cycs[1] - pulse_cycs[0]), 512'd23);
      check_eq("b2b_gap1", 512'(pulse_cycs[2] - pulse_cycs[1]), 512'd23);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
